// File: rtl/mmm_pkg.sv
// Shared types for the branch resolution path.
// Holds datapath width, queue depth and the queue entry bundle.
package mmm_pkg;

  localparam int XLEN      = 32;
  localparam int BRQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } brq_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// In-order queue of outstanding branch predictions.
// Ports: push/pop/clear in, head data, full/empty/count out.
module brq_fifo
  import mmm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  brq_entry_t               data_i,
  input  logic                     pop_i,
  output brq_entry_t               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  brq_entry_t     mem_q [DEPTH];
  brq_entry_t     mem_d [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      unique case (1'b1)
        do_push && !do_pop: cnt_d = cnt_q + CW'(1);
        do_pop && !do_push: cnt_d = cnt_q - CW'(1);
        default:            cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Matches fetch predictions against execute outcomes.
// Ports: pred_* from fetch, exe_* from execute, res_*/redirect out.
module branch_resolution_unit #(
  parameter int BRQ_DEPTH = mmm_pkg::BRQ_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          pred_valid_i,
  output logic                          pred_ready_o,
  input  logic [mmm_pkg::XLEN-1:0]      pred_pc_i,
  input  logic                          pred_taken_i,
  input  logic [mmm_pkg::XLEN-1:0]      pred_target_i,
  input  logic                          exe_valid_i,
  output logic                          exe_ready_o,
  input  logic                          exe_taken_i,
  input  logic [mmm_pkg::XLEN-1:0]      exe_target_i,
  output logic                          res_valid_o,
  output logic                          res_del_o,
  output logic [mmm_pkg::XLEN-1:0]      res_pc_o,
  output logic [mmm_pkg::XLEN-1:0]      res_target_o,
  output logic                          mispredict_o,
  output logic [mmm_pkg::XLEN-1:0]      redirect_pc_o,
  output logic [$clog2(BRQ_DEPTH):0]    count_o
);

  import mmm_pkg::*;

  brq_entry_t      wr_entry;
  brq_entry_t      head;
  logic            full;
  logic            empty;
  logic            push_ok;
  logic            pop_ok;
  logic            miss;
  logic            squash;

  logic            res_valid_q, res_valid_d;
  logic            res_del_q, res_del_d;
  logic [XLEN-1:0] res_pc_q, res_pc_d;
  logic [XLEN-1:0] res_tgt_q, res_tgt_d;
  logic            mispred_q, mispred_d;
  logic [XLEN-1:0] redir_q, redir_d;

  assign wr_entry.pc     = pred_pc_i;
  assign wr_entry.taken  = pred_taken_i;
  assign wr_entry.target = pred_target_i;

  assign push_ok = pred_valid_i && !full;
  assign pop_ok  = exe_valid_i && !empty && !flush_i;

  assign miss = (head.taken != exe_taken_i) ||
                (head.taken && exe_taken_i &&
                 (head.target != exe_target_i));

  // A wrong guess means every younger entry is wrong-path.
  assign squash = flush_i || (pop_ok && miss);

  brq_fifo #(
    .DEPTH (BRQ_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (squash),
    .push_i  (push_ok),
    .data_i  (wr_entry),
    .pop_i   (pop_ok),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  always_comb begin
    res_valid_d = 1'b0;
    res_del_d   = 1'b0;
    res_pc_d    = '0;
    res_tgt_d   = '0;
    mispred_d   = 1'b0;
    redir_d     = '0;
    if (pop_ok && miss) begin
      res_valid_d = 1'b1;
      res_pc_d    = head.pc;
      mispred_d   = 1'b1;
      if (exe_taken_i) begin
        res_tgt_d = exe_target_i;
        redir_d   = exe_target_i;
      end else begin
        res_del_d = 1'b1;
        redir_d   = head.pc + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_valid_q <= 1'b0;
      res_del_q   <= 1'b0;
      res_pc_q    <= '0;
      res_tgt_q   <= '0;
      mispred_q   <= 1'b0;
      redir_q     <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_del_q   <= res_del_d;
      res_pc_q    <= res_pc_d;
      res_tgt_q   <= res_tgt_d;
      mispred_q   <= mispred_d;
      redir_q     <= redir_d;
    end
  end

  assign pred_ready_o  = !full;
  assign exe_ready_o   = !empty;
  assign res_valid_o   = res_valid_q;
  assign res_del_o     = res_del_q;
  assign res_pc_o      = res_pc_q;
  assign res_target_o  = res_tgt_q;
  assign mispredict_o  = mispred_q;
  assign redirect_pc_o = redir_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit.
// Drives fetch/execute vectors and checks registered outputs.
module tb_branch_resolution_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        exe_valid;
  logic        exe_ready;
  logic        exe_taken;
  logic [31:0] exe_target;
  logic        res_valid;
  logic        res_del;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolution_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .flush_i       (flush),
    .pred_valid_i  (pred_valid),
    .pred_ready_o  (pred_ready),
    .pred_pc_i     (pred_pc),
    .pred_taken_i  (pred_taken),
    .pred_target_i (pred_target),
    .exe_valid_i   (exe_valid),
    .exe_ready_o   (exe_ready),
    .exe_taken_i   (exe_taken),
    .exe_target_i  (exe_target),
    .res_valid_o   (res_valid),
    .res_del_o     (res_del),
    .res_pc_o      (res_pc),
    .res_target_o  (res_target),
    .mispredict_o  (mispredict),
    .redirect_pc_o (redirect_pc),
    .count_o       (count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pred_valid  = 1'b0;
    exe_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic t,
                      input logic [31:0] tgt);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_taken  = t;
    pred_target = tgt;
  endtask

  task automatic resolve(input logic t,
                         input logic [31:0] tgt);
    exe_valid  = 1'b1;
    exe_taken  = t;
    exe_target = tgt;
  endtask

  function automatic logic [31:0] kpc(input int k);
    return 32'h1000 + 32'(4 * k);
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_in();
    exe_taken = 1'b0;
    exe_target = '0;
    push(32'h40, 1'b1, 32'h80);
    exe_valid = 1'b1;
    repeat (3) tick();
    chk("rst_pred_ready", 64'(pred_ready), 64'd1);
    chk("rst_exe_ready", 64'(exe_ready), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_del", 64'(res_del), 64'd0);
    chk("rst_res_pc", 64'(res_pc), 64'd0);
    chk("rst_res_target", 64'(res_target), 64'd0);
    chk("rst_mispredict", 64'(mispredict), 64'd0);
    chk("rst_redirect", 64'(redirect_pc), 64'd0);
    idle_in();
    rst_n = 1'b1;
    tick();

    push(32'h100, 1'b1, 32'h200);
    tick();
    chk("ok_count1", 64'(count), 64'd1);
    chk("ok_exe_ready", 64'(exe_ready), 64'd1);
    idle_in();
    resolve(1'b1, 32'h200);
    tick();
    chk("ok_count0", 64'(count), 64'd0);
    chk("ok_res_valid", 64'(res_valid), 64'd0);
    chk("ok_mispredict", 64'(mispredict), 64'd0);
    idle_in();
    tick();

    push(32'h100, 1'b1, 32'h200);
    tick();
    idle_in();
    resolve(1'b1, 32'h300);
    tick();
    idle_in();
    chk("tm_res_valid", 64'(res_valid), 64'd1);
    chk("tm_res_del", 64'(res_del), 64'd0);
    chk("tm_res_pc", 64'(res_pc), 64'h100);
    chk("tm_res_target", 64'(res_target), 64'h300);
    chk("tm_mispredict", 64'(mispredict), 64'd1);
    chk("tm_redirect", 64'(redirect_pc), 64'h300);
    chk("tm_count", 64'(count), 64'd0);
    tick();
    chk("tm_pulse_valid", 64'(res_valid), 64'd0);
    chk("tm_pulse_mis", 64'(mispredict), 64'd0);
    chk("tm_pulse_redir", 64'(redirect_pc), 64'd0);
    chk("tm_pulse_pc", 64'(res_pc), 64'd0);

    push(32'h100, 1'b1, 32'h180);
    tick();
    push(32'h180, 1'b0, 32'h0);
    tick();
    push(32'h184, 1'b0, 32'h0);
    tick();
    chk("dm_count3", 64'(count), 64'd3);
    push(32'h188, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    tick();
    idle_in();
    chk("dm_res_valid", 64'(res_valid), 64'd1);
    chk("dm_res_del", 64'(res_del), 64'd1);
    chk("dm_res_pc", 64'(res_pc), 64'h100);
    chk("dm_res_target", 64'(res_target), 64'd0);
    chk("dm_redirect", 64'(redirect_pc), 64'h104);
    chk("dm_count0", 64'(count), 64'd0);
    tick();
    chk("dm_after_count", 64'(count), 64'd0);

    for (int k = 0; k < 4; k++) begin
      push(kpc(k), 1'(k), kpc(k) + 32'h40);
      tick();
    end
    chk("fw_count4", 64'(count), 64'd4);
    chk("fw_ready0", 64'(pred_ready), 64'd0);
    push(kpc(4), 1'b0, kpc(4) + 32'h40);
    tick();
    chk("fw_reject_count", 64'(count), 64'd4);
    resolve(1'b0, 32'h0);
    tick();
    chk("fw_full_pop_count", 64'(count), 64'd3);
    chk("fw_full_pop_mis", 64'(mispredict), 64'd0);
    for (int j = 1; j <= 8; j++) begin
      push(kpc(j + 3), 1'(j + 3), kpc(j + 3) + 32'h40);
      resolve(1'(j), kpc(j) + 32'h40);
      tick();
      chk($sformatf("fw_pair%0d_mis", j), 64'(mispredict), 64'd0);
      chk($sformatf("fw_pair%0d_cnt", j), 64'(count), 64'd3);
    end
    idle_in();
    resolve(1'b0, 32'h0);
    tick();
    idle_in();
    chk("fw_head_pc", 64'(res_pc), 64'(kpc(9)));
    chk("fw_head_del", 64'(res_del), 64'd1);
    chk("fw_head_redir", 64'(redirect_pc), 64'(kpc(9) + 32'd4));
    chk("fw_drain_count", 64'(count), 64'd0);
    tick();

    push(32'hFFFF_FFFC, 1'b1, 32'h50);
    tick();
    idle_in();
    resolve(1'b0, 32'h0);
    tick();
    idle_in();
    chk("wr_mispredict", 64'(mispredict), 64'd1);
    chk("wr_res_pc", 64'(res_pc), 64'hFFFF_FFFC);
    chk("wr_redirect", 64'(redirect_pc), 64'd0);

    push(32'h200, 1'b0, 32'h0);
    tick();
    chk("fl_count1", 64'(count), 64'd1);
    push(32'h204, 1'b0, 32'h0);
    resolve(1'b1, 32'h999);
    flush = 1'b1;
    tick();
    idle_in();
    chk("fl_res_valid", 64'(res_valid), 64'd0);
    chk("fl_mispredict", 64'(mispredict), 64'd0);
    chk("fl_count0", 64'(count), 64'd0);
    chk("fl_exe_ready", 64'(exe_ready), 64'd0);
    tick();
    chk("fl_after_mis", 64'(mispredict), 64'd0);

    push(32'h300, 1'b0, 32'h0);
    tick();
    push(32'h304, 1'b0, 32'h0);
    tick();
    idle_in();
    chk("mr_count2", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_count0", 64'(count), 64'd0);
    chk("mr_ready", 64'(pred_ready), 64'd1);
    tick();
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
